// File: rtl/fetch_pc_gen.sv
// Fetch program-counter generator: boot cycle, sequential stepping, prioritised
// trap/branch redirects, and a WFI halt state with a one-entry redirect buffer.
module fetch_pc_gen #(
  parameter int unsigned        width_p      = 32,
  parameter logic [width_p-1:0] reset_vec_p  = '0,
  parameter bit                 compressed_p = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               trap_valid_i,
  input  logic [width_p-1:0] trap_pc_i,
  input  logic               redirect_valid_i,
  input  logic [width_p-1:0] redirect_pc_i,
  input  logic               halt_i,
  input  logic               wake_i,
  input  logic               ready_i,
  input  logic               compressed_i,
  output logic [width_p-1:0] pc_o,
  output logic               valid_o,
  output logic               misalign_o
);

  typedef enum logic [1:0] {
    boot_s,
    run_s,
    halt_s
  } state_e;

  // Target bits that must be zero: bit 0 always, bit 1 too without 16-bit instructions.
  localparam logic [width_p-1:0] low_mask_c = compressed_p ? {{(width_p-1){1'b0}}, 1'b1}
                                                           : {{(width_p-2){1'b0}}, 2'b11};

  state_e             state_q;
  logic               pend_q;
  logic [width_p-1:0] pend_pc_q;
  logic               fire;
  logic [width_p-1:0] step;

  function automatic logic [width_p-1:0] align(input logic [width_p-1:0] t);
    return t & ~low_mask_c;
  endfunction

  function automatic logic misaligned(input logic [width_p-1:0] t);
    return |(t & low_mask_c);
  endfunction

  assign fire = valid_o & ready_i;
  assign step = (compressed_p && compressed_i) ? {{(width_p-3){1'b0}}, 3'd2}
                                               : {{(width_p-3){1'b0}}, 3'd4};

  // NOTE: every register here, including the pending buffer, uses non-blocking
  // assignments and is cleared by the async reset so no stale target survives a reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= boot_s;
      pc_o       <= reset_vec_p;
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      misalign_o <= 1'b0;
      case (state_q)
        boot_s: begin
          state_q <= run_s;
          valid_o <= 1'b1;
        end

        run_s: begin
          if (trap_valid_i) begin
            pc_o       <= align(trap_pc_i);
            misalign_o <= misaligned(trap_pc_i);
          end else begin
            if (redirect_valid_i) begin
              pc_o       <= align(redirect_pc_i);
              misalign_o <= misaligned(redirect_pc_i);
            end else if (fire) begin
              pc_o <= pc_o + step;
            end
            if (halt_i) begin
              state_q <= halt_s;
              valid_o <= 1'b0;
            end
          end
        end

        halt_s: begin
          if (trap_valid_i) begin
            pc_o       <= align(trap_pc_i);
            misalign_o <= misaligned(trap_pc_i);
            pend_q     <= 1'b0;
            state_q    <= run_s;
            valid_o    <= 1'b1;
          end else if (wake_i) begin
            // A same-cycle redirect is newer than anything buffered.
            if (redirect_valid_i) begin
              pc_o       <= align(redirect_pc_i);
              misalign_o <= misaligned(redirect_pc_i);
            end else if (pend_q) begin
              pc_o       <= align(pend_pc_q);
              misalign_o <= misaligned(pend_pc_q);
            end
            pend_q  <= 1'b0;
            state_q <= run_s;
            valid_o <= 1'b1;
          end else if (redirect_valid_i) begin
            pend_q    <= 1'b1;
            pend_pc_q <= redirect_pc_i;
          end
        end

        default: begin
          state_q <= boot_s;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed table, mid-HALT reset sequence,
// and random stimulus against an abstract model, on a 16-bit and a 32-bit-only instance.
module tb_fetch_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        trap_valid_i, redirect_valid_i, halt_i, wake_i, ready_i, compressed_i;
  logic [31:0] trap_pc_i, redirect_pc_i;
  logic [31:0] pc_a, pc_b;
  logic        valid_a, valid_b, mis_a, mis_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk_i = ~clk_i;

  fetch_pc_gen #(.width_p(32), .reset_vec_p(32'h100), .compressed_p(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .wake_i(wake_i), .ready_i(ready_i), .compressed_i(compressed_i),
    .pc_o(pc_a), .valid_o(valid_a), .misalign_o(mis_a)
  );

  fetch_pc_gen #(.width_p(32), .reset_vec_p(32'h100), .compressed_p(1'b0)) dut_nc (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .wake_i(wake_i), .ready_i(ready_i), .compressed_i(compressed_i),
    .pc_o(pc_b), .valid_o(valid_b), .misalign_o(mis_b)
  );

  typedef struct {
    logic        trap;
    logic [31:0] tpc;
    logic        rd;
    logic [31:0] rpc;
    logic        halt, wake, rdy, cmp;
    logic [31:0] epc;
    logic        ev, em;
  } vec_t;

  // Abstract model, index 1 = 16-bit capable instance, index 0 = 32-bit only.
  typedef enum int {m_boot, m_run, m_halt} mode_e;
  mode_e       m_mode [2];
  logic [31:0] m_pc   [2];
  logic        m_mis  [2];
  logic        m_pv   [2];
  logic [31:0] m_pp   [2];

  function automatic vec_t mk(logic trap, logic [31:0] tpc, logic rd, logic [31:0] rpc,
                              logic halt, logic wake, logic rdy, logic cmp,
                              logic [31:0] epc, logic ev, logic em);
    vec_t v;
    v.trap = trap; v.tpc = tpc; v.rd = rd; v.rpc = rpc;
    v.halt = halt; v.wake = wake; v.rdy = rdy; v.cmp = cmp;
    v.epc = epc; v.ev = ev; v.em = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = m_boot; m_pc[c] = 32'h100; m_mis[c] = 1'b0; m_pv[c] = 1'b0; m_pp[c] = '0;
    end
  endtask

  task automatic model_load(input int c, input logic [31:0] t);
    logic [31:0] lowm;
    lowm = (c == 1) ? 32'h1 : 32'h3;
    m_pc[c]  = t & ~lowm;
    m_mis[c] = (t & lowm) != 0;
  endtask

  task automatic model_step(input int c);
    m_mis[c] = 1'b0;
    case (m_mode[c])
      m_boot: m_mode[c] = m_run;
      m_run: begin
        if (trap_valid_i) model_load(c, trap_pc_i);
        else begin
          if (redirect_valid_i) model_load(c, redirect_pc_i);
          else if (ready_i) m_pc[c] = m_pc[c] + ((c == 1 && compressed_i) ? 32'd2 : 32'd4);
          if (halt_i) m_mode[c] = m_halt;
        end
      end
      default: begin
        if (trap_valid_i) begin
          model_load(c, trap_pc_i); m_pv[c] = 1'b0; m_mode[c] = m_run;
        end else if (wake_i) begin
          if (redirect_valid_i) model_load(c, redirect_pc_i);
          else if (m_pv[c]) model_load(c, m_pp[c]);
          m_pv[c] = 1'b0; m_mode[c] = m_run;
        end else if (redirect_valid_i) begin
          m_pv[c] = 1'b1; m_pp[c] = redirect_pc_i;
        end
      end
    endcase
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"},      pc_a,    m_pc[1]);
    check({tag, " valid"},   {31'b0, valid_a}, {31'b0, m_mode[1] == m_run});
    check({tag, " mis"},     {31'b0, mis_a},   {31'b0, m_mis[1]});
    check({tag, " nc pc"},   pc_b,    m_pc[0]);
    check({tag, " nc valid"},{31'b0, valid_b}, {31'b0, m_mode[0] == m_run});
    check({tag, " nc mis"},  {31'b0, mis_b},   {31'b0, m_mis[0]});
  endtask

  // Drive one cycle of inputs, clock it, then compare; hard also checks the table's constants.
  task automatic apply(input vec_t v, input bit hard, input string tag);
    trap_valid_i = v.trap; trap_pc_i = v.tpc;
    redirect_valid_i = v.rd; redirect_pc_i = v.rpc;
    halt_i = v.halt; wake_i = v.wake; ready_i = v.rdy; compressed_i = v.cmp;
    model_step(0);
    model_step(1);
    @(posedge clk_i);
    #1;
    if (hard) begin
      check({tag, " tbl pc"},    pc_a, v.epc);
      check({tag, " tbl valid"}, {31'b0, valid_a}, {31'b0, v.ev});
      check({tag, " tbl mis"},   {31'b0, mis_a},   {31'b0, v.em});
    end
    check_model(tag);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst_ni = 1'b0;
    trap_valid_i = 0; trap_pc_i = '0; redirect_valid_i = 0; redirect_pc_i = '0;
    halt_i = 0; wake_i = 0; ready_i = 1; compressed_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset pc", pc_a, 32'h100);
    check("reset valid", {31'b0, valid_a}, 32'd0);
    check("reset mis", {31'b0, mis_a}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //                trap tpc           rd rpc           hlt wk rdy cmp  exp_pc        v  m
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 0,  32'h100,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 0,  32'h104,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 0,  32'h108,      1, 0));
    tbl.push_back(mk(0, 0,             1, 32'h200,       0, 0, 1, 0,  32'h200,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 1,  32'h202,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 0,  32'h206,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 1,  32'h208,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 0, 1,  32'h208,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 0, 0,  32'h208,      1, 0));
    tbl.push_back(mk(1, 32'h8000_0000, 1, 32'h400,       0, 0, 1, 0,  32'h8000_0000,1, 0));
    tbl.push_back(mk(0, 0,             1, 32'h400,       0, 0, 0, 0,  32'h400,      1, 0));
    tbl.push_back(mk(0, 0,             1, 32'h403,       0, 0, 1, 0,  32'h402,      1, 1));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 0, 0,  32'h402,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             1, 0, 1, 0,  32'h406,      0, 0));
    tbl.push_back(mk(0, 0,             1, 32'h600,       0, 0, 1, 0,  32'h406,      0, 0));
    tbl.push_back(mk(0, 0,             1, 32'h700,       0, 0, 1, 0,  32'h406,      0, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 0,  32'h406,      0, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 1, 1, 0,  32'h700,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             1, 0, 0, 0,  32'h700,      0, 0));
    tbl.push_back(mk(0, 0,             1, 32'h555,       0, 0, 0, 0,  32'h700,      0, 0));
    tbl.push_back(mk(1, 32'h900,       0, 0,             0, 1, 0, 0,  32'h900,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 0, 0,  32'h900,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             1, 0, 0, 0,  32'h900,      0, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 1, 0, 0,  32'h900,      1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             1, 1, 0, 0,  32'h900,      0, 0));
    tbl.push_back(mk(0, 0,             1, 32'h7FF,       1, 0, 0, 0,  32'h900,      0, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 1, 0, 0,  32'h7FE,      1, 1));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 0, 0,  32'h7FE,      1, 0));
    tbl.push_back(mk(0, 0,             1, 32'hFFFF_FFFC, 0, 0, 0, 0,  32'hFFFF_FFFC,1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 0,  32'h0,        1, 0));
    tbl.push_back(mk(0, 0,             1, 32'hFFFF_FFFE, 0, 0, 1, 0,  32'hFFFF_FFFE,1, 0));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 1, 1,  32'h0,        1, 0));
    tbl.push_back(mk(1, 32'h8000_0001, 0, 0,             1, 0, 1, 0,  32'h8000_0000,1, 1));
    tbl.push_back(mk(0, 0,             0, 0,             0, 0, 0, 0,  32'h8000_0000,1, 0));

    foreach (tbl[i]) begin
      apply(tbl[i], 1'b1, $sformatf("vec%0d", i));
      if (i == 11) begin
        check("nc align pc", pc_b, 32'h400);
        check("nc align mis", {31'b0, mis_b}, 32'd1);
      end
    end

    // Reset in HALT with a redirect pending: no stale target may appear after boot.
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, "pre-rst halt");
    apply(mk(0, 0, 1, 32'hABC, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre-rst pend");
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check("midrst pc", pc_a, 32'h100);
    check("midrst valid", {31'b0, valid_a}, 32'd0);
    check("midrst nc pc", pc_b, 32'h100);
    @(negedge clk_i);
    rst_ni = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 0), 1'b1, "reboot");
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 0), 1'b1, "reboot halt");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h100, 1, 0), 1'b1, "reboot wake");

    for (int i = 0; i < 3000; i++) begin
      v.trap = ($urandom_range(0, 15) == 0);
      v.tpc  = $urandom();
      v.rd   = ($urandom_range(0, 5) == 0);
      v.rpc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
      v.halt = ($urandom_range(0, 9) == 0);
      v.wake = ($urandom_range(0, 3) == 0);
      v.rdy  = $urandom_range(0, 1);
      v.cmp  = $urandom_range(0, 1);
      v.epc  = '0; v.ev = 0; v.em = 0;
      apply(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
